// File: rtl/sim_stat.sv
// sim_stat: simulation status monitor that counts DUV progress/error pulses and raises a finish
// request with a latched verdict. Optional idle watchdog is built when SIM_STAT_WDOG_EN is defined.
module sim_stat #(
  parameter int WDOG_CYCLES = 1000,
  parameter int ERR_LIMIT   = 8
) (
  input  logic        sim_stat_clk_ip,
  input  logic        sim_stat_rst_n_ip,
  input  logic        sim_stat_evt_ip,
  input  logic        sim_stat_err_ip,
  input  logic        sim_stat_done_ip,
  input  logic        sim_stat_ack_ip,
  output logic        sim_stat_req_op,
  output logic        sim_stat_pass_op,
  output logic [1:0]  sim_stat_reason_op,
  output logic [31:0] sim_stat_evt_cnt_op,
  output logic [15:0] sim_stat_err_cnt_op
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0]  RSN_NONE  = 2'b00;
  localparam logic [1:0]  RSN_DONE  = 2'b01;
  localparam logic [1:0]  RSN_ERR   = 2'b10;
  localparam logic [1:0]  RSN_WDOG  = 2'b11;
  localparam logic [15:0] ERR_LIM_C = 16'(ERR_LIMIT);

  state_e      state_r;
  state_e      state_nxt_s;
  logic        req_r;
  logic        pass_r;
  logic [1:0]  reason_r;
  logic [31:0] evt_cnt_r;
  logic [15:0] err_cnt_r;
  logic        req_nxt_s;
  logic        pass_nxt_s;
  logic [1:0]  reason_nxt_s;
  logic        err_trig_s;
  logic        wdog_trig_s;
  logic        done_trig_s;

  // Limit check uses the registered count, so the request follows one cycle after it is reached
  assign err_trig_s  = (err_cnt_r == ERR_LIM_C);
  assign done_trig_s = sim_stat_done_ip;

`ifdef SIM_STAT_WDOG_EN
  localparam logic [15:0] WDOG_LAST_C = 16'(WDOG_CYCLES - 1);
  logic [15:0] idle_cnt_r;

  // Idle-cycle counter: cleared by progress and held at zero once the run has ended
  always_ff @(posedge sim_stat_clk_ip) begin
    if (!sim_stat_rst_n_ip) begin
      idle_cnt_r <= 16'd0;
    end else if ((state_r != ST_RUN) || sim_stat_evt_ip) begin
      idle_cnt_r <= 16'd0;
    end else if (idle_cnt_r != WDOG_LAST_C) begin
      idle_cnt_r <= idle_cnt_r + 16'd1;
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  assign wdog_trig_s = (idle_cnt_r == WDOG_LAST_C) && !sim_stat_evt_ip;
`else
  logic unused_wdog_s;
  assign unused_wdog_s = (WDOG_CYCLES > 1);
  assign wdog_trig_s   = 1'b0;
`endif

  // Saturating event and error counters, active in every state
  always_ff @(posedge sim_stat_clk_ip) begin
    if (!sim_stat_rst_n_ip) begin
      evt_cnt_r <= 32'd0;
      err_cnt_r <= 16'd0;
    end else begin
      if (sim_stat_evt_ip && (evt_cnt_r != 32'hFFFF_FFFF)) begin
        evt_cnt_r <= evt_cnt_r + 32'd1;
      end else begin
        evt_cnt_r <= evt_cnt_r;
      end
      if (sim_stat_err_ip && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge sim_stat_clk_ip) begin
    if (!sim_stat_rst_n_ip) begin
      state_r  <= ST_RUN;
      req_r    <= 1'b0;
      pass_r   <= 1'b0;
      reason_r <= RSN_NONE;
    end else begin
      state_r  <= state_nxt_s;
      req_r    <= req_nxt_s;
      pass_r   <= pass_nxt_s;
      reason_r <= reason_nxt_s;
    end
  end

  // Next-state logic; DONE is terminal until reset
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (err_trig_s || wdog_trig_s || done_trig_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_REQ: begin
        if (sim_stat_ack_ip) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE: state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Verdict is latched only on leaving RUN, with error limit over watchdog over done
  always_comb begin
    req_nxt_s    = (state_nxt_s == ST_REQ);
    reason_nxt_s = reason_r;
    pass_nxt_s   = pass_r;
    if (state_r == ST_RUN) begin
      if (err_trig_s) begin
        reason_nxt_s = RSN_ERR;
        pass_nxt_s   = 1'b0;
      end else if (wdog_trig_s) begin
        reason_nxt_s = RSN_WDOG;
        pass_nxt_s   = 1'b0;
      end else if (done_trig_s) begin
        reason_nxt_s = RSN_DONE;
        pass_nxt_s   = (err_cnt_r == 16'd0) && !sim_stat_err_ip;
      end else begin
        reason_nxt_s = reason_r;
        pass_nxt_s   = pass_r;
      end
    end else begin
      reason_nxt_s = reason_r;
      pass_nxt_s   = pass_r;
    end
  end

  assign sim_stat_req_op     = req_r;
  assign sim_stat_pass_op    = pass_r;
  assign sim_stat_reason_op  = reason_r;
  assign sim_stat_evt_cnt_op = evt_cnt_r;
  assign sim_stat_err_cnt_op = err_cnt_r;

endmodule
